ca_frame_reader: RTL and testbench

- Reader side of the 512-cell cellular-automaton core. It sits beside the automaton and watches the same `ca_load` that drives the core's `load`.
- On request it snapshots one generation of the core's `q` and streams it out as a framed sequence of W-bit words over a valid/ready handshake.
- Each frame is one header word carrying the generation index, followed by N/W data words.
- It feeds the debug/trace path, so the automaton runs free and is never stalled.

---
 rtl/ca_frame_reader.sv | 112 +++++++++++
 tb/tb_ca_frame_reader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ca_frame_reader.sv
// Snapshot reader for the cellular-automaton core: captures one generation of q
// and streams it as a header word plus N/W data words over valid/ready.
module ca_frame_reader #(
  parameter int          N      = 512,
  parameter int          W      = 32,
  parameter logic [15:0] MARKER = 16'hA110
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ca_load,
  input  logic [N-1:0] q_in,
  input  logic         start,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic         overrun
);

  localparam int BEATS = N / W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]    state_q,   state_d;
  logic [BW-1:0] beat_q,    beat_d;
  logic [15:0]   gen_cnt_q, gen_cnt_d;
  logic [15:0]   hdr_gen_q, hdr_gen_d;
  logic [N-1:0]  shadow_q,  shadow_d;
  logic          overrun_q, overrun_d;
  logic          fire;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    hdr_gen_d = hdr_gen_q;
    shadow_d  = shadow_q;
    overrun_d = overrun_q;
    fire      = out_valid & out_ready;

    // Counter tracks the generation currently on q_in; the core is never stalled.
    if (ca_load)
      gen_cnt_d = '0;
    else if (gen_cnt_q == 16'hFFFF)
      gen_cnt_d = gen_cnt_q;
    else
      gen_cnt_d = gen_cnt_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          shadow_d  = q_in;
          hdr_gen_d = gen_cnt_q;
          state_d   = S_HDR;
        end
      end
      S_HDR: begin
        if (start) overrun_d = 1'b1;
        if (fire) begin
          state_d = S_DATA;
          beat_d  = '0;
        end
      end
      S_DATA: begin
        if (start) overrun_d = 1'b1;
        if (fire) begin
          if (beat_q == LAST_BEAT)
            state_d = S_IDLE;
          else
            beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode registered state only, so out_ready never reaches out_valid.
  always_comb begin
    out_valid = (state_q == S_HDR) || (state_q == S_DATA);
    busy      = (state_q != S_IDLE);
    overrun   = overrun_q;
    out_last  = (state_q == S_DATA) && (beat_q == LAST_BEAT);
    out_data  = '0;
    if (state_q == S_HDR)
      out_data[31:0] = {MARKER, hdr_gen_q};
    else if (state_q == S_DATA)
      out_data = shadow_q[int'(beat_q)*W +: W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      gen_cnt_q <= '0;
      hdr_gen_q <= '0;
      shadow_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      gen_cnt_q <= gen_cnt_d;
      hdr_gen_q <= hdr_gen_d;
      shadow_q  <= shadow_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_ca_frame_reader.sv
// Directed bench for ca_frame_reader: table-driven backpressure frame plus
// hand-written sequences for seed frame, overrun, abort and saturation.
module tb_ca_frame_reader;

  localparam int N     = 512;
  localparam int W     = 32;
  localparam int BEATS = N / W;

  logic         clk = 1'b0;
  logic         reset;
  logic         ca_load;
  logic [N-1:0] q_in;
  logic         start;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;
  logic         overrun;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        ready;
    logic        valid;
    logic [31:0] data;
    logic        last;
    logic        busy;
  } vec_t;

  vec_t        vecs [20];
  logic [31:0] words [16];

  ca_frame_reader #(.N(N), .W(W), .MARKER(16'hA110)) dut (
    .clk       (clk),
    .reset     (reset),
    .ca_load   (ca_load),
    .q_in      (q_in),
    .start     (start),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drains a whole frame with out_ready held high, header already valid.
  task automatic frame_ready_high(input string tag, input logic [31:0] hdr, input logic [31:0] w [16]);
    out_ready = 1'b1;
    check({tag, "_hdr_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_hdr_data"}, out_data, hdr);
    check({tag, "_hdr_last"}, {31'd0, out_last}, 32'd0);
    step();
    for (int i = 0; i < BEATS; i++) begin
      check($sformatf("%s_valid%0d", tag, i), {31'd0, out_valid}, 32'd1);
      check($sformatf("%s_data%0d", tag, i), out_data, w[i]);
      check($sformatf("%s_last%0d", tag, i), {31'd0, out_last}, (i == BEATS - 1) ? 32'd1 : 32'd0);
      step();
    end
    check({tag, "_end_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    ca_load   = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    q_in      = '0;

    // Reset state
    step();
    step();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_data", out_data, 32'd0);
    reset = 1'b0;
    step();

    // Seed frame at generation 0, only cell 256 alive
    q_in      = '0;
    q_in[256] = 1'b1;
    ca_load   = 1'b1;
    step();
    ca_load = 1'b0;
    start   = 1'b1;
    step();
    start = 1'b0;
    q_in  = '1;
    for (int i = 0; i < BEATS; i++) words[i] = 32'h0;
    words[8] = 32'h0000_0001;
    frame_ready_high("seed", 32'hA110_0000, words);
    check("seed_overrun", {31'd0, overrun}, 32'd0);
    step();

    // Generation index 3 with a 3-cycle stall on data word 5
    for (int i = 0; i < BEATS; i++) q_in[i*W +: W] = 32'hC0DE_0000 | i;
    vecs[0] = '{ready: 1'b1, valid: 1'b1, data: 32'hA110_0003, last: 1'b0, busy: 1'b1};
    begin
      int k = 1;
      for (int d = 0; d < BEATS; d++) begin
        if (d == 5) begin
          for (int s = 0; s < 3; s++) begin
            vecs[k] = '{ready: 1'b0, valid: 1'b1, data: 32'hC0DE_0005, last: 1'b0, busy: 1'b1};
            k++;
          end
        end
        vecs[k] = '{ready: 1'b1, valid: 1'b1, data: 32'hC0DE_0000 | d,
                    last: (d == BEATS - 1), busy: 1'b1};
        k++;
      end
    end
    ca_load = 1'b1;
    step();
    ca_load = 1'b0;
    step();
    step();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    q_in  = '0;
    for (int i = 0; i < 20; i++) begin
      out_ready = vecs[i].ready;
      check($sformatf("bp_valid%0d", i), {31'd0, out_valid}, {31'd0, vecs[i].valid});
      check($sformatf("bp_data%0d", i), out_data, vecs[i].data);
      check($sformatf("bp_last%0d", i), {31'd0, out_last}, {31'd0, vecs[i].last});
      check($sformatf("bp_busy%0d", i), {31'd0, busy}, {31'd0, vecs[i].busy});
      step();
    end
    check("bp_end_valid", {31'd0, out_valid}, 32'd0);
    check("bp_end_busy", {31'd0, busy}, 32'd0);
    step();

    // Overrun at beat 4, then reset during beat 10
    for (int i = 0; i < BEATS; i++) q_in[i*W +: W] = 32'hAB00_0000 | i;
    out_ready = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    check("ov_hdr_data", out_data[31:16], 32'h0000_A110);
    step();
    for (int b = 0; b < 4; b++) begin
      check($sformatf("ov_data%0d", b), out_data, 32'hAB00_0000 | b);
      step();
    end
    check("ov_before", {31'd0, overrun}, 32'd0);
    check("ov_data4", out_data, 32'hAB00_0004);
    start = 1'b1;
    step();
    start = 1'b0;
    check("ov_set", {31'd0, overrun}, 32'd1);
    for (int b = 5; b < 10; b++) begin
      check($sformatf("ov_data%0d", b), out_data, 32'hAB00_0000 | b);
      check($sformatf("ov_busy%0d", b), {31'd0, busy}, 32'd1);
      step();
    end
    check("ov_data10", out_data, 32'hAB00_000A);
    check("ov_sticky", {31'd0, overrun}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_overrun", {31'd0, overrun}, 32'd0);
    check("abort_last", {31'd0, out_last}, 32'd0);
    step();
    check("abort_idle", {31'd0, busy}, 32'd0);

    // Reset and start together: no snapshot
    reset = 1'b1;
    start = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    check("rststart_busy", {31'd0, busy}, 32'd0);
    step();
    check("rststart_valid", {31'd0, out_valid}, 32'd0);

    // Generation counter saturation
    ca_load = 1'b0;
    out_ready = 1'b0;
    repeat (70000) step();
    for (int i = 0; i < BEATS; i++) q_in[i*W +: W] = 32'h5A5A_0000 | i;
    for (int i = 0; i < BEATS; i++) words[i] = 32'h5A5A_0000 | i;
    start = 1'b1;
    step();
    start = 1'b0;
    frame_ready_high("sat", 32'hA110_FFFF, words);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
